// File: rtl/first_one_iterator.sv
// first_one_iterator
//
// Walks the set bits of a mask one at a time, lowest bit first. A mask is
// accepted over a valid/ready handshake. Each of its set bits then appears as
// one output beat, carried both as a one-hot vector and as a binary index.
// The final beat of a mask raises out_last. A new mask can be accepted on the
// same edge as the final beat, so beats keep flowing at one per cycle across
// mask boundaries.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high; discards any enumeration in flight
//   in_mask    - mask to enumerate, sampled on the input handshake
//   in_valid   - in_mask is valid
//   in_ready   - a new mask can be accepted this cycle
//   out_onehot - one-hot of the lowest bit not yet emitted (0 when idle)
//   out_index  - binary position of out_onehot (0 when idle)
//   out_last   - current beat is the final set bit of the mask
//   out_valid  - out_onehot, out_index and out_last are valid
//   out_ready  - downstream accepts the current beat
//   busy       - an enumeration is in progress (same as out_valid)

module first_one_iterator #(
    parameter int WIDTH = 8,
    localparam int INDEX_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_mask,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_onehot,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic {
        IDLE,
        ITERATE
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       remaining_q, remaining_d;
    logic [WIDTH-1:0]       first;
    logic [INDEX_WIDTH-1:0] firstIndex;
    logic                   inFire;
    logic                   outFire;

    // Lowest set bit of the remaining bits: adding one to the inverted value
    // carries up to exactly that position.
    assign first = remaining_q & (~remaining_q + WIDTH'(1));

    // Binary position of the one-hot. Each position ORs in its own index, so
    // the top bit encodes exactly even when WIDTH is not a power of two.
    always_comb begin
        firstIndex = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (first[i]) begin
                firstIndex = firstIndex | INDEX_WIDTH'(i);
            end
        end
    end

    assign out_valid  = (state_q == ITERATE);
    assign busy       = out_valid;
    assign out_onehot = out_valid ? first : '0;
    assign out_index  = out_valid ? firstIndex : '0;
    assign out_last   = out_valid && ((remaining_q & ~first) == '0);

    // Accept a new mask when idle, or on the final beat of the current mask
    // so that the next mask's first beat follows with no gap.
    assign in_ready = (state_q == IDLE) || (out_valid && out_ready && out_last);
    assign inFire   = in_valid && in_ready;
    assign outFire  = out_valid && out_ready;

    // Next-state logic. A newly accepted mask overrides the clearing done by
    // the final beat. An all-zero mask is taken in but emits nothing.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (outFire) begin
            if (out_last) begin
                remaining_d = '0;
                state_d     = IDLE;
            end else begin
                remaining_d = remaining_q & ~first;
            end
        end
        if (inFire) begin
            remaining_d = in_mask;
            state_d     = (in_mask != '0) ? ITERATE : IDLE;
        end
    end

    // Reset wins over any handshake on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_first_one_iterator.sv
// tb_first_one_iterator
//
// Bench for first_one_iterator. Accepted masks are turned into their list of
// set bits (ascending), which is queued as expected beats. A separate monitor
// drives out_ready and pops one expected beat per output handshake.

module tb_first_one_iterator;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_mask;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic [2:0] out_index;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t expQ[$];
    int    beatCycles[$];
    int    total = 0;
    int    bad = 0;
    int    cycleCount = 0;
    bit    readyRandom = 0;
    bit    readyForce = 1;
    bit    recordBeats = 0;

    first_one_iterator #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_mask   (in_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_onehot(out_onehot),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected beats for a mask: its set positions in ascending order, with
    // last marking the final one.
    task automatic pushExpected(input logic [7:0] mask);
        int    bits[$];
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) bits.push_back(i);
        end
        for (int j = 0; j < bits.size(); j++) begin
            b.idx  = bits[j];
            b.last = (j == bits.size() - 1);
            expQ.push_back(b);
        end
    endtask

    // Called right after a falling edge. Holds the mask until it is accepted,
    // then returns at the next falling edge with in_valid low, so it can be
    // called again at once for back-to-back masks.
    task automatic applyStimulus(input logic [7:0] mask);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_mask  = mask;
        #2;
        while (!in_ready && waitCycles < 200) begin
            @(negedge clock);
            #2;
            waitCycles++;
        end
        checkOutput("inAcceptTimeout", int'(in_ready), 1);
        if (in_ready) pushExpected(mask);
        @(negedge clock);
        in_valid = 1'b0;
        in_mask  = 8'($urandom);
    endtask

    // Waits until every expected beat has been seen and the block is idle.
    task automatic waitIdle();
        int n = 0;
        #2;
        while (!(in_ready && !out_valid && expQ.size() == 0) && n < 500) begin
            @(negedge clock);
            #2;
            n++;
        end
        checkOutput("drainTimeout", int'(n < 500), 1);
    endtask

    // Monitor: drives out_ready, checks every handshake beat against the
    // queue, and checks that a stalled beat is held unchanged.
    initial begin
        bit         prevStall = 0;
        logic [7:0] prevOnehot = '0;
        logic [2:0] prevIndex = '0;
        logic       prevLast = 1'b0;
        beat_t      e;
        out_ready = 1'b1;
        forever begin
            @(negedge clock);
            #1;
            out_ready = readyRandom ? ($urandom_range(3) != 0) : readyForce;
            #1;
            cycleCount++;
            if (reset) begin
                prevStall = 0;
            end else begin
                checkOutput("busyEqValid", int'(busy), int'(out_valid));
                if (prevStall) begin
                    checkOutput("stallValid", int'(out_valid), 1);
                    checkOutput("stallOnehot", int'(out_onehot), int'(prevOnehot));
                    checkOutput("stallIndex", int'(out_index), int'(prevIndex));
                    checkOutput("stallLast", int'(out_last), int'(prevLast));
                end
                if (!out_valid) begin
                    checkOutput("idleOnehot", int'(out_onehot), 0);
                end else if (out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedBeat", int'(out_index), -1);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beatIndex", int'(out_index), e.idx);
                        checkOutput("beatOnehot", int'(out_onehot), 1 << e.idx);
                        checkOutput("beatLast", int'(out_last), int'(e.last));
                        if (recordBeats) beatCycles.push_back(cycleCount);
                    end
                end
                prevStall  = out_valid && !out_ready;
                prevOnehot = out_onehot;
                prevIndex  = out_index;
                prevLast   = out_last;
            end
        end
    end

    // Directed scenarios, then every mask with random backpressure.
    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_mask  = 8'hFF;
        readyForce = 1;
        repeat (2) @(negedge clock);
        #2;
        checkOutput("rstValid", int'(out_valid), 0);
        checkOutput("rstOnehot", int'(out_onehot), 0);
        checkOutput("rstIndex", int'(out_index), 0);
        checkOutput("rstLast", int'(out_last), 0);
        checkOutput("rstReady", int'(in_ready), 1);
        checkOutput("rstBusy", int'(busy), 0);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        #2;
        checkOutput("postRstValid", int'(out_valid), 0);
        checkOutput("postRstOnehot", int'(out_onehot), 0);
        checkOutput("postRstReady", int'(in_ready), 1);

        @(negedge clock);
        applyStimulus(8'b1010_0100);
        waitIdle();

        @(negedge clock);
        applyStimulus(8'b1010_0100);
        @(negedge clock);
        readyForce = 0;
        repeat (3) @(negedge clock);
        readyForce = 1;
        waitIdle();

        @(negedge clock);
        applyStimulus(8'h00);
        #2;
        checkOutput("zeroMaskReady", int'(in_ready), 1);
        checkOutput("zeroMaskValid", int'(out_valid), 0);
        @(negedge clock);
        applyStimulus(8'h80);
        waitIdle();

        @(negedge clock);
        recordBeats = 1;
        applyStimulus(8'b0000_0011);
        applyStimulus(8'b0001_0000);
        waitIdle();
        recordBeats = 0;
        checkOutput("b2bCount", beatCycles.size(), 3);
        if (beatCycles.size() == 3) begin
            checkOutput("b2bGap1", beatCycles[1] - beatCycles[0], 1);
            checkOutput("b2bGap2", beatCycles[2] - beatCycles[1], 1);
        end

        @(negedge clock);
        applyStimulus(8'hFF);
        @(negedge clock);
        reset = 1'b1;
        expQ.delete();
        @(negedge clock);
        reset = 1'b0;
        #2;
        checkOutput("midRstValid", int'(out_valid), 0);
        checkOutput("midRstReady", int'(in_ready), 1);
        @(negedge clock);
        applyStimulus(8'h01);
        waitIdle();

        readyRandom = 1;
        for (int m = 0; m < 256; m++) begin
            @(negedge clock);
            applyStimulus(8'(m));
        end
        waitIdle();
        checkOutput("queueEmpty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/first_one_iterator.md
Name: first_one_iterator

Overview:
- Sequential bit-set enumerator built around the small_first_one priority stage.
- Accepts a WIDTH-bit mask over a valid/ready handshake and emits each set bit, LSB first, one per output handshake.
- Each output beat carries the bit as a one-hot vector and as a binary index, with a last flag on the final beat.
- Sits upstream of schedulers and arbiters that service requesters one at a time from a request bitmap.

Parameters:
- WIDTH, 8, width of the input mask and of the one-hot output; must be ≥ 2.
- INDEX_WIDTH, $clog2(WIDTH), width of the binary index output; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_mask  input  WIDTH  mask to enumerate; sampled on the input handshake.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a new mask this cycle.
- out_onehot  output  WIDTH  one-hot of the lowest remaining set bit.
- out_index  output  INDEX_WIDTH  binary position of out_onehot.
- out_last  output  1  current beat is the final set bit of the mask.
- out_valid  output  1  out_onehot, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- busy  output  1  an enumeration is in progress; equal to out_valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- State: two-state FSM, IDLE and ITERATE.
- Register remaining[WIDTH-1:0] holds the bits not yet emitted.
- Reset state: FSM = IDLE, remaining = 0.
  - Outputs in reset: in_ready = 1, out_valid = 0, busy = 0, out_onehot = 0, out_index = 0, out_last = 0.
- Combinational outputs from remaining:
  - first = small_first_one(remaining).
  - out_onehot = first when out_valid, else 0.
  - out_index = binary encode of first when out_valid, else 0.
  - out_last = out_valid && ((remaining & ~first) == 0).
- out_valid = (state == ITERATE).
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This lets a new mask load on the same edge as the final beat, with no bubble.
- Input handshake (in_valid && in_ready):
  - remaining <= in_mask.
  - Next state = ITERATE if in_mask != 0, else IDLE.
  - A zero mask is consumed silently and produces no output beats.
- Output handshake (out_valid && out_ready), not last: remaining <= remaining & ~first; stay in ITERATE.
- Output handshake, last:
  - If an input handshake also fires, the input handshake rule applies.
  - Otherwise remaining <= 0 and go to IDLE.
- Backpressure: while out_valid && !out_ready, remaining and all outputs hold stable. in_ready stays 0 unless the last-beat bypass condition holds.
- Latency: first beat is valid the cycle after the input handshake. A mask with k set bits needs k output handshakes.
  - Sustained throughput: 1 beat/cycle, including across mask boundaries with the bypass.
- in_mask and in_valid are ignored whenever in_ready = 0.
- Reset mid-enumeration: the next edge returns to IDLE and remaining = 0. Pending beats are discarded and not resumed.
- Reset has priority over simultaneous handshakes.
- Index encoding must be exact for bit WIDTH-1, including when WIDTH is not a power of two.

Test Plan:
- Reset with in_valid = 1, in_mask = 8'hFF, out_ready = 1 → during and on the cycle after reset, out_valid = 0, out_onehot = 0, in_ready = 1; no beats emitted.
- in_mask = 8'b1010_0100 accepted, out_ready = 1 → beats on consecutive cycles:
  - index 2 (onehot 00000100)
  - index 5 (00100000)
  - index 7 (10000000), with out_last = 1 only on this beat
  - then in_ready = 1 and out_valid = 0.
- Same mask with out_ready low for 3 cycles on the second beat → index 5 / onehot 00100000 held stable throughout; sequence resumes 5, 7 with no skip or duplicate.
- in_mask = 8'h00, then 8'h80 → zero mask emits nothing and in_ready stays 1; 8'h80 emits a single beat, index 7, out_last = 1.
- Back-to-back: 8'b0000_0011, then 8'b0001_0000 presented during the last beat → indices 0, 1, 4 on three consecutive cycles; the second mask is accepted on the index-1 handshake edge.
- Reset asserted on the second beat of 8'hFF → the next cycle has out_valid = 0 and in_ready = 1; a new mask 8'h01 then emits only index 0.
- Exhaustive run, all 256 masks with random out_ready → the concatenated beats of each mask equal its set bits in ascending order, with exactly one out_last per nonzero mask.
